riscv_mc_seq: RTL and testbench



---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/riscv_mc_wait_cnt.sv | 37 +++
 rtl/riscv_mc_seq.sv | 193 +++++++++++++++++++
 tb/tb_riscv_mc_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RV64I multi-cycle sequencer.
// Holds the base opcodes, the FSM state type and the datapath select encodings.
package riscv_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] RF_ALU  = 2'd0;
  localparam logic [1:0] RF_LOAD = 2'd1;
  localparam logic [1:0] RF_PC4  = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_SYSTEM  = 2'd2;
  localparam logic [1:0] TC_BUS     = 2'd3;

  // SYSTEM counts as known here; it is trapped separately with its own cause.
  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE,
      MISC_MEM, SYSTEM, OP_IMM_32, OP_32: is_known_opcode = 1'b1;
      default:                            is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_wait_cnt.sv
// Memory wait-cycle counter: counts cycles a request goes unanswered and
// flags expiry once MEM_TIMEOUT wait cycles have elapsed.
module riscv_mc_wait_cnt #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT);

  logic [15:0] cnt_q, cnt_d;

  // Saturates at the limit; the sequencer leaves the waiting state right after.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/riscv_mc_seq.sv
// Multi-cycle sequencer for the RV64I core: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, drives memory handshakes and counts retirements.
module riscv_mc_seq
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_rvalid,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_rvalid,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             waitClear, waitEnable, waitExpired;

  // The counter restarts whenever the state changes, i.e. on entry to FETCH or MEM.
  assign waitClear  = (state_d != state_q);
  assign waitEnable = ((state_q == S_FETCH) && !imem_rvalid) ||
                      ((state_q == S_MEM)   && !dmem_rvalid);

  riscv_mc_wait_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (waitClear),
    .enable_i (waitEnable),
    .expired_o(waitExpired)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    rf_we    = 1'b0;
    rf_wsel  = RF_ALU;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (waitExpired) begin
          state_d = S_TRAP;
          cause_d = TC_BUS;
        end
      end
      S_DECODE: begin
        if (!is_known_opcode(opcode)) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else if (opcode == SYSTEM) begin
          state_d = S_TRAP;
          cause_d = TC_SYSTEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP, OP_32: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          OP_IMM, OP_IMM_32: begin
            alu_op  = ALU_FUNCT;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          LUI, AUIPC: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          LOAD, STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          BRANCH: begin
            alu_op  = ALU_BRANCH;
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          JAL: begin
            rf_we   = 1'b1;
            rf_wsel = RF_PC4;
            pc_we   = 1'b1;
            pc_sel  = PC_IMM;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          JALR: begin
            alu_src = 1'b1;
            rf_we   = 1'b1;
            rf_wsel = RF_PC4;
            pc_we   = 1'b1;
            pc_sel  = PC_ALU;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == STORE);
        if (dmem_rvalid) begin
          if (opcode == STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (waitExpired) begin
          state_d = S_TRAP;
          cause_d = TC_BUS;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = (opcode == LOAD) ? RF_LOAD : RF_ALU;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
      end
    endcase
    // Strobes must be quiet while reset is held, even though the state reads FETCH.
    if (!rst_n) begin
      retire   = 1'b0;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cause_q   <= TC_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign halted     = rst_n && (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_riscv_mc_seq.sv
// Randomized bench for riscv_mc_seq: each instruction's expected latency and
// strobe pattern is derived from its class and the memory delays.
module tb_riscv_mc_seq;

  localparam int T = 4;

  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_LUI       = 7'b0110111;
  localparam logic [6:0] C_AUIPC     = 7'b0010111;
  localparam logic [6:0] C_OP        = 7'b0110011;
  localparam logic [6:0] C_JAL       = 7'b1101111;
  localparam logic [6:0] C_JALR      = 7'b1100111;
  localparam logic [6:0] C_BRANCH    = 7'b1100011;
  localparam logic [6:0] C_LOAD      = 7'b0000011;
  localparam logic [6:0] C_STORE     = 7'b0100011;
  localparam logic [6:0] C_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] C_SYSTEM    = 7'b1110011;
  localparam logic [6:0] C_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] C_OP_32     = 7'b0111011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0;
  logic        imem_req, imem_rvalid = 1'b0;
  logic        dmem_req, dmem_we, dmem_rvalid = 1'b0;
  logic        ir_we, pc_we, rf_we, alu_src, halted;
  logic [1:0]  pc_sel, rf_wsel, alu_op, trap_cause;
  logic [63:0] instret;

  int          total = 0;
  int          bad = 0;
  logic [63:0] retired = '0;

  always #5 clk = ~clk;

  riscv_mc_seq #(.MEM_TIMEOUT(T), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .rf_wsel(rf_wsel), .alu_src(alu_src), .alu_op(alu_op),
    .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold reset for one cycle, then release just after a rising edge so the
  // next full cycle is the first FETCH cycle.
  task automatic doReset();
    @(negedge clk);
    imem_rvalid = 1'b0;
    dmem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_imem_req", 64'(imem_req), 64'd0);
    checkOutput("reset_instret", instret, 64'd0);
    checkOutput("reset_halted", 64'(halted), 64'd0);
    checkOutput("reset_cause", 64'(trap_cause), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    retired = '0;
  endtask

  // di: wait cycles before imem_rvalid; dd: wait cycles before dmem_rvalid.
  task automatic applyStimulus(input logic [6:0] op, input int di, input int dd, input logic taken);
    int   expEnd, expRf, expDmem, expPcWe, expImem;
    logic expHalt, expWe, chkAlu, expAluSrc;
    logic [1:0] expWsel, expPcSel, expCause, expAluOp;
    int   endCycle, imemCnt, irCnt, dmemCnt, rfCnt, pcCnt;
    logic weSeen, haltObs, aluSrcObs;
    logic [1:0] wselObs, pcSelObs, aluOpObs;
    logic isMem;

    expHalt = 1'b0; expCause = 2'd0; expRf = 0; expWsel = 2'd0; expPcSel = 2'd0;
    expDmem = 0; expWe = 1'b0; chkAlu = 1'b0; expAluSrc = 1'b0; expAluOp = 2'd0;
    expEnd = 0;
    isMem = (op == C_LOAD) || (op == C_STORE);
    expImem = (di > T) ? T + 1 : di + 1;

    if (di > T) begin
      expHalt = 1'b1; expCause = 2'd3; expEnd = T + 2;
    end else begin
      case (op)
        C_OP, C_OP_32, C_OP_IMM, C_OP_IMM_32, C_LUI, C_AUIPC: begin
          expEnd = di + 4; expRf = 1; chkAlu = 1'b1;
          expAluOp  = (op == C_LUI || op == C_AUIPC) ? 2'b00 : 2'b10;
          expAluSrc = !(op == C_OP || op == C_OP_32);
        end
        C_LOAD, C_STORE: begin
          chkAlu = 1'b1; expAluSrc = 1'b1; expAluOp = 2'b00;
          expWe = (op == C_STORE);
          if (dd > T) begin
            expHalt = 1'b1; expCause = 2'd3; expEnd = di + 5 + T; expDmem = T + 1;
          end else begin
            expDmem = dd + 1;
            expEnd  = (op == C_LOAD) ? di + 5 + dd : di + 4 + dd;
            if (op == C_LOAD) begin expRf = 1; expWsel = 2'd1; end
          end
        end
        C_BRANCH: begin
          expEnd = di + 3; expPcSel = taken ? 2'd1 : 2'd0; chkAlu = 1'b1;
          expAluOp = 2'b01;
          expAluSrc = alu_src;
        end
        C_JAL:      begin expEnd = di + 3; expRf = 1; expWsel = 2'd2; expPcSel = 2'd1; end
        C_JALR:     begin
          expEnd = di + 3; expRf = 1; expWsel = 2'd2; expPcSel = 2'd2;
          chkAlu = 1'b1; expAluSrc = 1'b1; expAluOp = 2'b00;
        end
        C_MISC_MEM: begin expEnd = di + 3; end
        C_SYSTEM:   begin expHalt = 1'b1; expCause = 2'd2; expEnd = di + 3; end
        default:    begin expHalt = 1'b1; expCause = 2'd1; expEnd = di + 3; end
      endcase
    end
    expPcWe = expHalt ? 0 : 1;

    endCycle = 0; imemCnt = 0; irCnt = 0; dmemCnt = 0; rfCnt = 0; pcCnt = 0;
    weSeen = 1'b0; haltObs = 1'b0; aluSrcObs = 1'b0;
    wselObs = 2'd0; pcSelObs = 2'd0; aluOpObs = 2'd0;

    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      opcode       = (c <= di + 1) ? 7'($urandom) : op;
      imem_rvalid  = (c == di + 1);
      dmem_rvalid  = (c <= di + 1) ? 1'($urandom) : (c == di + 4 + dd);
      branch_taken = taken;
      #1;
      if (imem_req) imemCnt++;
      if (ir_we) irCnt++;
      if (dmem_req) begin dmemCnt++; weSeen = weSeen | dmem_we; end
      if (rf_we) begin rfCnt++; wselObs = rf_wsel; end
      if (pc_we) begin pcCnt++; pcSelObs = pc_sel; end
      if (c == di + 3) begin aluSrcObs = alu_src; aluOpObs = alu_op; end
      if (halted) begin haltObs = 1'b1; endCycle = c; break; end
      if (pc_we) begin endCycle = c; break; end
    end
    @(posedge clk);
    #1;
    if (!expHalt) retired = retired + 64'd1;

    checkOutput("end_cycle", 64'(endCycle), 64'(expEnd));
    checkOutput("halted", 64'(haltObs), 64'(expHalt));
    checkOutput("imem_req_cycles", 64'(imemCnt), 64'(expImem));
    checkOutput("ir_we_pulses", 64'(irCnt), (di > T) ? 64'd0 : 64'd1);
    checkOutput("dmem_req_cycles", 64'(dmemCnt), 64'(expDmem));
    checkOutput("pc_we_pulses", 64'(pcCnt), 64'(expPcWe));
    checkOutput("rf_we_pulses", 64'(rfCnt), 64'(expRf));
    checkOutput("instret", instret, retired);
    if (isMem && di <= T) checkOutput("dmem_we", 64'(weSeen), 64'(expWe));
    if (expRf != 0) checkOutput("rf_wsel", 64'(wselObs), 64'(expWsel));
    if (!expHalt) checkOutput("pc_sel", 64'(pcSelObs), 64'(expPcSel));
    if (chkAlu && di <= T) begin
      checkOutput("alu_op", 64'(aluOpObs), 64'(expAluOp));
      if (op != C_BRANCH) checkOutput("alu_src", 64'(aluSrcObs), 64'(expAluSrc));
    end
    if (expHalt) checkOutput("trap_cause", 64'(trap_cause), 64'(expCause));
  endtask

  // A trapped sequencer stays silent until reset.
  task automatic checkTrapSticky(input logic [1:0] cause);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      imem_rvalid = 1'($urandom);
      dmem_rvalid = 1'($urandom);
      #1;
      checkOutput("trap_no_imem_req", 64'(imem_req | dmem_req | pc_we | rf_we), 64'd0);
      checkOutput("trap_cause_held", 64'(trap_cause), 64'(cause));
    end
  endtask

  logic [6:0] legalOps [12];

  initial begin
    legalOps = '{C_OP_IMM, C_LUI, C_AUIPC, C_OP, C_JAL, C_JALR, C_BRANCH,
                 C_LOAD, C_STORE, C_MISC_MEM, C_OP_IMM_32, C_OP_32};

    doReset();

    applyStimulus(C_OP_IMM, 1, 0, 1'b0);
    applyStimulus(C_LOAD, 0, 3, 1'b0);
    applyStimulus(C_LOAD, 0, 0, 1'b0);
    applyStimulus(C_BRANCH, 0, 0, 1'b1);
    applyStimulus(C_BRANCH, 0, 0, 1'b0);
    applyStimulus(C_JAL, 0, 0, 1'b0);
    applyStimulus(C_JALR, 2, 0, 1'b1);
    applyStimulus(C_LUI, 0, 0, 1'b0);
    applyStimulus(C_OP, 0, 0, 1'b0);
    applyStimulus(C_STORE, 0, 0, 1'b0);
    applyStimulus(C_MISC_MEM, 0, 0, 1'b0);
    applyStimulus(C_OP_32, T, 0, 1'b0);
    applyStimulus(C_STORE, 1, T, 1'b0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(legalOps[$urandom_range(0, 11)], int'($urandom_range(0, T)),
                    int'($urandom_range(0, T)), 1'($urandom));
    end

    applyStimulus(7'b1111111, 0, 0, 1'b0);
    checkTrapSticky(2'd1);
    doReset();
    applyStimulus(C_OP_IMM, 0, 0, 1'b0);

    applyStimulus(C_SYSTEM, 1, 0, 1'b0);
    checkTrapSticky(2'd2);
    doReset();

    applyStimulus(C_OP, 20, 0, 1'b0);
    checkTrapSticky(2'd3);
    doReset();

    applyStimulus(C_LOAD, 0, 20, 1'b0);
    checkTrapSticky(2'd3);
    doReset();

    // Reset arrives while a store is waiting in MEM.
    applyStimulus(C_ADDI_DUMMY_OP(), 0, 0, 1'b0);
    @(negedge clk); opcode = C_STORE; imem_rvalid = 1'b1; dmem_rvalid = 1'b0;
    @(negedge clk); imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("mid_store_dmem_req", 64'(dmem_req), 64'd1);
    checkOutput("mid_store_instret", instret, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("mid_reset_strobes", 64'(imem_req | pc_we | rf_we | ir_we), 64'd0);
    checkOutput("mid_reset_instret", instret, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    retired = '0;
    applyStimulus(C_JAL, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [6:0] C_ADDI_DUMMY_OP();
    return C_OP_IMM;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
